// File: rtl/mem_stage_ls.sv
// mem_stage_ls - MIPS pipeline memory stage with a variable-latency data memory.
//
// Takes an instruction from the EX/MEM register and handles byte, halfword and
// word loads and stores over a req/ack memory handshake. Store data is
// lane-replicated and given byte enables. Load data is lane-selected and then
// sign- or zero-extended. Misaligned accesses are trapped. The MEM/WB register
// lives here. Upstream stages are frozen while an access is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, an ack watchdog aborts an access that has sat in WAIT for
//   TIMEOUT cycles without an ack. It also adds the o_exc_BusErr output.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_MEM_*                  instruction and operands from EX/MEM
//   i_WB_*                   write-back controls carried through to MEM/WB
//   o_MEM_mem_* / i_MEM_mem_* data memory request / response handshake
//   o_IF_*                   branch resolution back to fetch
//   o_stall                  freeze IF/ID/EX and the EX/MEM register
//   o_exc_Misalign           one-cycle misaligned-access pulse (aligned with WB)
//   o_WB_*                   registered MEM/WB outputs
//   o_exc_BusErr             one-cycle ack-timeout pulse (MEM_TIMEOUT_EN only)
//
// state  | meaning
// S_IDLE | no access outstanding; current EX/MEM instruction is decoded live
// S_WAIT | memory request outstanding; request driven from captured registers
module mem_stage_ls #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_MEM_valid,
  input  logic              i_MEM_ctrl_MemRead,
  input  logic              i_MEM_ctrl_MemWrite,
  input  logic [1:0]        i_MEM_ctrl_Size,
  input  logic              i_MEM_ctrl_Unsigned,
  input  logic              i_MEM_ctrl_Branch,
  input  logic              i_MEM_data_Zero,
  input  logic [ADDR_W-1:0] i_MEM_data_PCBranch,
  input  logic [DATA_W-1:0] i_MEM_data_ALUOut,
  input  logic [DATA_W-1:0] i_MEM_data_RTData,
  input  logic              i_WB_ctrl_Mem2Reg,
  input  logic              i_WB_ctrl_RegWrite,
  input  logic [REG_AW-1:0] i_WB_data_RegAddrW,
  output logic              o_MEM_mem_Req,
  output logic              o_MEM_mem_We,
  output logic [ADDR_W-1:0] o_MEM_mem_Addr,
  output logic [3:0]        o_MEM_mem_ByteEn,
  output logic [DATA_W-1:0] o_MEM_mem_DataW,
  input  logic              i_MEM_mem_Ack,
  input  logic [DATA_W-1:0] i_MEM_mem_DataR,
  output logic              o_IF_ctrl_PCSrc,
  output logic [ADDR_W-1:0] o_IF_data_PCBranch,
  output logic              o_stall,
  output logic              o_exc_Misalign,
  output logic              o_WB_valid,
  output logic [DATA_W-1:0] o_WB_data_MemData,
  output logic [DATA_W-1:0] o_WB_data_ALUData,
  output logic              o_WB_ctrl_Mem2Reg,
  output logic              o_WB_ctrl_RegWrite,
  output logic [REG_AW-1:0] o_WB_data_RegAddrW
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              o_exc_BusErr
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;

  // Snapshot of the instruction that owns the outstanding access
  logic              cap_rd, cap_we, cap_uns, cap_m2r, cap_rw;
  logic [1:0]        cap_size;
  logic [DATA_W-1:0] cap_alu, cap_rt;
  logic [REG_AW-1:0] cap_rad;

  logic              in_wait, in_mem, in_misalign, issue;
  logic              cur_rd, cur_we, cur_uns, cur_m2r, cur_rw;
  logic [1:0]        cur_size, cur_off;
  logic [DATA_W-1:0] cur_alu, cur_rt;
  logic [REG_AW-1:0] cur_rad;
  logic              fin_ok, fin_kill, fin, tmo_hit;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_data;

  assign in_wait     = (state == S_WAIT);
  assign in_mem      = i_MEM_valid & (i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite);
  // Size 11 is reserved and is checked like a word
  assign in_misalign = ((i_MEM_ctrl_Size == 2'b01) & i_MEM_data_ALUOut[0]) |
                       (i_MEM_ctrl_Size[1] & (i_MEM_data_ALUOut[1:0] != 2'b00));
  assign issue       = ~in_wait & in_mem & ~in_misalign;

  // One datapath serves both states: live inputs in IDLE, the snapshot in WAIT
  assign cur_rd   = in_wait ? cap_rd   : i_MEM_ctrl_MemRead;
  assign cur_we   = in_wait ? cap_we   : i_MEM_ctrl_MemWrite;
  assign cur_uns  = in_wait ? cap_uns  : i_MEM_ctrl_Unsigned;
  assign cur_m2r  = in_wait ? cap_m2r  : i_WB_ctrl_Mem2Reg;
  assign cur_rw   = in_wait ? cap_rw   : i_WB_ctrl_RegWrite;
  assign cur_size = in_wait ? cap_size : i_MEM_ctrl_Size;
  assign cur_alu  = in_wait ? cap_alu  : i_MEM_data_ALUOut;
  assign cur_rt   = in_wait ? cap_rt   : i_MEM_data_RTData;
  assign cur_rad  = in_wait ? cap_rad  : i_WB_data_RegAddrW;
  assign cur_off  = cur_alu[1:0];

  // Request is gated by rst so a reset during WAIT drops it at once
  assign o_MEM_mem_Req  = ~rst & (in_wait | issue);
  assign o_MEM_mem_We   = o_MEM_mem_Req & cur_we;
  assign o_MEM_mem_Addr = {cur_alu[ADDR_W-1:2], 2'b00};
  assign o_stall        = o_MEM_mem_Req & ~i_MEM_mem_Ack;

  assign o_IF_ctrl_PCSrc    = i_MEM_valid & i_MEM_ctrl_Branch & i_MEM_data_Zero;
  assign o_IF_data_PCBranch = i_MEM_data_PCBranch;

  always_comb begin
    o_MEM_mem_ByteEn = 4'b1111;
    o_MEM_mem_DataW  = cur_rt;
    case (cur_size)
      2'b00: begin
        o_MEM_mem_ByteEn = 4'b0001 << cur_off;
        o_MEM_mem_DataW  = {4{cur_rt[7:0]}};
      end
      2'b01: begin
        o_MEM_mem_ByteEn = cur_off[1] ? 4'b1100 : 4'b0011;
        o_MEM_mem_DataW  = {2{cur_rt[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b    = i_MEM_mem_DataR[{cur_off, 3'b000} +: 8];
    lane_h    = cur_off[1] ? i_MEM_mem_DataR[31:16] : i_MEM_mem_DataR[15:0];
    load_data = i_MEM_mem_DataR;
    case (cur_size)
      2'b00:   load_data = {{(DATA_W-8){~cur_uns & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{(DATA_W-16){~cur_uns & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  // Down-counter loaded on entry to WAIT; terminal count aborts the access
  assign tmo_hit = in_wait & ~i_MEM_mem_Ack & (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  // fin_ok: instruction retires normally; fin_kill: retires with RegWrite suppressed
  assign fin_ok   = in_wait ? i_MEM_mem_Ack
                            : (i_MEM_valid & ~(in_mem & in_misalign) & (~in_mem | i_MEM_mem_Ack));
  assign fin_kill = in_wait ? tmo_hit : (in_mem & in_misalign);
  assign fin      = fin_ok | fin_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cap_rd             <= 1'b0;
      cap_we             <= 1'b0;
      cap_uns            <= 1'b0;
      cap_m2r            <= 1'b0;
      cap_rw             <= 1'b0;
      cap_size           <= 2'b00;
      cap_alu            <= '0;
      cap_rt             <= '0;
      cap_rad            <= '0;
      o_WB_valid         <= 1'b0;
      o_WB_ctrl_RegWrite <= 1'b0;
      o_WB_ctrl_Mem2Reg  <= 1'b0;
      o_WB_data_RegAddrW <= '0;
      o_WB_data_ALUData  <= '0;
      o_WB_data_MemData  <= '0;
      o_exc_Misalign     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt            <= '0;
      o_exc_BusErr       <= 1'b0;
`endif
    end else begin
      // Anything not retiring this cycle becomes an all-zero bubble
      o_WB_valid         <= fin;
      o_WB_ctrl_RegWrite <= fin_ok & cur_rw;
      o_WB_ctrl_Mem2Reg  <= fin & cur_m2r;
      o_WB_data_RegAddrW <= fin ? cur_rad : '0;
      o_WB_data_ALUData  <= fin ? cur_alu : '0;
      o_WB_data_MemData  <= (fin_ok & cur_rd) ? load_data : '0;
      o_exc_Misalign     <= fin_kill & ~in_wait;
`ifdef MEM_TIMEOUT_EN
      o_exc_BusErr       <= fin_kill & in_wait;
`endif
      if (state == S_IDLE) begin
        if (issue & ~i_MEM_mem_Ack) begin
          state    <= S_WAIT;
          cap_rd   <= i_MEM_ctrl_MemRead;
          cap_we   <= i_MEM_ctrl_MemWrite;
          cap_uns  <= i_MEM_ctrl_Unsigned;
          cap_m2r  <= i_WB_ctrl_Mem2Reg;
          cap_rw   <= i_WB_ctrl_RegWrite;
          cap_size <= i_MEM_ctrl_Size;
          cap_alu  <= i_MEM_data_ALUOut;
          cap_rt   <= i_MEM_data_RTData;
          cap_rad  <= i_WB_data_RegAddrW;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt  <= CNT_W'(TIMEOUT - 1);
`endif
        end
      end else if (fin) begin
        state <= S_IDLE;
      end
`ifdef MEM_TIMEOUT_EN
      else begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Randomized scoreboard bench for mem_stage_ls. A driver issues instructions
// and acts as the data memory. A reference model pushes the expected MEM/WB
// contents. A negedge monitor pops and compares whenever o_WB_valid is seen.
module tb_mem_stage_ls;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_MEM_valid, i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite;
  logic [1:0]  i_MEM_ctrl_Size;
  logic        i_MEM_ctrl_Unsigned, i_MEM_ctrl_Branch, i_MEM_data_Zero;
  logic [31:0] i_MEM_data_PCBranch, i_MEM_data_ALUOut, i_MEM_data_RTData;
  logic        i_WB_ctrl_Mem2Reg, i_WB_ctrl_RegWrite;
  logic [4:0]  i_WB_data_RegAddrW;
  logic        o_MEM_mem_Req, o_MEM_mem_We;
  logic [31:0] o_MEM_mem_Addr, o_MEM_mem_DataW;
  logic [3:0]  o_MEM_mem_ByteEn;
  logic        i_MEM_mem_Ack;
  logic [31:0] i_MEM_mem_DataR;
  logic        o_IF_ctrl_PCSrc;
  logic [31:0] o_IF_data_PCBranch;
  logic        o_stall, o_exc_Misalign, o_WB_valid;
  logic [31:0] o_WB_data_MemData, o_WB_data_ALUData;
  logic        o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
  logic [4:0]  o_WB_data_RegAddrW;
`ifdef MEM_TIMEOUT_EN
  logic        o_exc_BusErr;
`endif

  mem_stage_ls dut (
    .clk(clk), .rst(rst),
    .i_MEM_valid(i_MEM_valid), .i_MEM_ctrl_MemRead(i_MEM_ctrl_MemRead),
    .i_MEM_ctrl_MemWrite(i_MEM_ctrl_MemWrite), .i_MEM_ctrl_Size(i_MEM_ctrl_Size),
    .i_MEM_ctrl_Unsigned(i_MEM_ctrl_Unsigned), .i_MEM_ctrl_Branch(i_MEM_ctrl_Branch),
    .i_MEM_data_Zero(i_MEM_data_Zero), .i_MEM_data_PCBranch(i_MEM_data_PCBranch),
    .i_MEM_data_ALUOut(i_MEM_data_ALUOut), .i_MEM_data_RTData(i_MEM_data_RTData),
    .i_WB_ctrl_Mem2Reg(i_WB_ctrl_Mem2Reg), .i_WB_ctrl_RegWrite(i_WB_ctrl_RegWrite),
    .i_WB_data_RegAddrW(i_WB_data_RegAddrW),
    .o_MEM_mem_Req(o_MEM_mem_Req), .o_MEM_mem_We(o_MEM_mem_We),
    .o_MEM_mem_Addr(o_MEM_mem_Addr), .o_MEM_mem_ByteEn(o_MEM_mem_ByteEn),
    .o_MEM_mem_DataW(o_MEM_mem_DataW), .i_MEM_mem_Ack(i_MEM_mem_Ack),
    .i_MEM_mem_DataR(i_MEM_mem_DataR), .o_IF_ctrl_PCSrc(o_IF_ctrl_PCSrc),
    .o_IF_data_PCBranch(o_IF_data_PCBranch), .o_stall(o_stall),
    .o_exc_Misalign(o_exc_Misalign), .o_WB_valid(o_WB_valid),
    .o_WB_data_MemData(o_WB_data_MemData), .o_WB_data_ALUData(o_WB_data_ALUData),
    .o_WB_ctrl_Mem2Reg(o_WB_ctrl_Mem2Reg), .o_WB_ctrl_RegWrite(o_WB_ctrl_RegWrite),
    .o_WB_data_RegAddrW(o_WB_data_RegAddrW)
`ifdef MEM_TIMEOUT_EN
    , .o_exc_BusErr(o_exc_BusErr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid, rd, wr, uns, br, zero, m2r, rw;
    bit [1:0]  size;
    bit [31:0] pcb, alu, rt, rdata;
    bit [4:0]  rad;
    int        lat;
  } txn_t;

  typedef struct {
    bit [31:0] mem, alu;
    bit        m2r, rw, mis;
    bit [4:0]  rad;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input bit [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input txn_t t);
    return (t.alu % nbytes(t.size)) != 0;
  endfunction

  function automatic bit [3:0] exp_be(input txn_t t);
    int n = nbytes(t.size);
    return 4'(((1 << n) - 1) << (t.alu % 4));
  endfunction

  function automatic bit [31:0] exp_dw(input txn_t t);
    bit [31:0] d;
    int n = nbytes(t.size);
    for (int i = 0; i < 4; i++) d[8*i +: 8] = t.rt[8*(i % n) +: 8];
    return d;
  endfunction

  function automatic bit [31:0] exp_load(input txn_t t);
    int n = nbytes(t.size);
    bit [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    bit [31:0] v = (t.rdata >> (8 * (t.alu % 4))) & mask;
    if (!t.uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic wb_t model(input txn_t t);
    wb_t e;
    bit mem = t.rd | t.wr;
    e.alu = t.alu; e.m2r = t.m2r; e.rad = t.rad;
    e.mis = mem && is_mis(t);
    e.rw  = e.mis ? 1'b0 : t.rw;
    e.mem = (t.rd && !e.mis) ? exp_load(t) : 32'd0;
    return e;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic drive(input txn_t t);
    i_MEM_valid = t.valid; i_MEM_ctrl_MemRead = t.rd; i_MEM_ctrl_MemWrite = t.wr;
    i_MEM_ctrl_Size = t.size; i_MEM_ctrl_Unsigned = t.uns; i_MEM_ctrl_Branch = t.br;
    i_MEM_data_Zero = t.zero; i_MEM_data_PCBranch = t.pcb; i_MEM_data_ALUOut = t.alu;
    i_MEM_data_RTData = t.rt; i_WB_ctrl_Mem2Reg = t.m2r; i_WB_ctrl_RegWrite = t.rw;
    i_WB_data_RegAddrW = t.rad;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction leaves MEM
  task automatic run_txn(input txn_t t);
    bit expect_req = t.valid && (t.rd || t.wr) && !is_mis(t);
    bit done = 0;
    int cyc = 0, stalls = 0;
    drive(t);
    i_MEM_mem_Ack = 0; i_MEM_mem_DataR = $urandom;
    if (t.valid) exp_q.push_back(model(t));
    check("pcbranch", o_IF_data_PCBranch, t.pcb);
    while (!done) begin
      #3;
      check("req", o_MEM_mem_Req, expect_req);
      if (expect_req) begin
        check("addr", o_MEM_mem_Addr, t.alu & 32'hFFFF_FFFC);
        check("we", o_MEM_mem_We, t.wr);
        if (t.wr) begin
          check("byteen", o_MEM_mem_ByteEn, exp_be(t));
          check("dataw", o_MEM_mem_DataW, exp_dw(t));
        end
        if (cyc == t.lat) begin i_MEM_mem_Ack = 1; i_MEM_mem_DataR = t.rdata; end
      end else if ($urandom_range(0, 3) == 0) begin
        i_MEM_mem_Ack = 1;   // stray ack with no request must be ignored
      end
      @(negedge clk);
      check("stall", o_stall, expect_req && !i_MEM_mem_Ack);
      check("pcsrc", o_IF_ctrl_PCSrc, t.valid && t.br && t.zero);
      if (o_stall) stalls++;
      done = !expect_req || i_MEM_mem_Ack;
      @(posedge clk); #1;
      i_MEM_mem_Ack = 0; i_MEM_mem_DataR = $urandom;
      cyc++;
      if (!done && cyc > 20) begin
        checks++;
        $display("FAIL ack_wait: no completion after %0d cycles, required %0d", cyc, t.lat);
        done = 1;
      end
    end
    check("stall_cycles", stalls, expect_req ? t.lat : 0);
  endtask

  task automatic idle(input int n);
    i_MEM_valid = 0; i_MEM_ctrl_MemRead = 0; i_MEM_ctrl_MemWrite = 0; i_MEM_ctrl_Branch = 0;
    i_MEM_mem_Ack = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic txn_t mk(input bit rd, input bit wr, input bit [1:0] size, input bit uns,
                              input bit [31:0] alu, input bit [31:0] rt, input bit [31:0] rdata,
                              input int lat);
    txn_t t;
    t.valid = 1; t.rd = rd; t.wr = wr; t.size = size; t.uns = uns; t.br = 0; t.zero = 0;
    t.pcb = $urandom; t.alu = alu; t.rt = rt; t.rdata = rdata; t.lat = lat;
    t.m2r = rd; t.rw = !wr; t.rad = 5'($urandom);
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k = $urandom_range(0, 9);
    t.valid = ($urandom_range(0, 9) != 0);
    t.rd = (k < 4); t.wr = (k >= 4 && k < 7);
    t.size = 2'($urandom); t.uns = 1'($urandom); t.br = 1'($urandom); t.zero = 1'($urandom);
    t.pcb = $urandom; t.alu = $urandom; t.rt = $urandom; t.rdata = $urandom;
    t.m2r = 1'($urandom); t.rw = 1'($urandom); t.rad = 5'($urandom);
    t.lat = $urandom_range(0, 4);
    return t;
  endfunction

  // ---------------- monitor ----------------
  wb_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_WB_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL wb_unexpected: got valid WB alu=%h, required none", o_WB_data_ALUData);
        end else begin
          e = exp_q.pop_front();
          check("wb_memdata", o_WB_data_MemData, e.mem);
          check("wb_aludata", o_WB_data_ALUData, e.alu);
          check("wb_regwrite", o_WB_ctrl_RegWrite, e.rw);
          check("wb_mem2reg", o_WB_ctrl_Mem2Reg, e.m2r);
          check("wb_regaddr", o_WB_data_RegAddrW, e.rad);
          check("wb_misalign", o_exc_Misalign, e.mis);
        end
      end else begin
        check("bubble_regwrite", o_WB_ctrl_RegWrite, 0);
        check("bubble_misalign", o_exc_Misalign, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    txn_t t;
    idle(0);
    i_MEM_ctrl_Size = 0; i_MEM_ctrl_Unsigned = 0; i_MEM_data_Zero = 0;
    i_MEM_data_PCBranch = 0; i_MEM_data_ALUOut = 0; i_MEM_data_RTData = 0;
    i_WB_ctrl_Mem2Reg = 0; i_WB_ctrl_RegWrite = 0; i_WB_data_RegAddrW = 0; i_MEM_mem_DataR = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", o_WB_valid, 0);
    check("rst_req", o_MEM_mem_Req, 0);
    check("rst_stall", o_stall, 0);
    check("rst_misalign", o_exc_Misalign, 0);
    check("rst_memdata", o_WB_data_MemData, 0);
    check("rst_regwrite", o_WB_ctrl_RegWrite, 0);
    @(posedge clk); #1;
    rst = 0;

    // word load, ack three cycles after the request
    run_txn(mk(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3));
    // signed then unsigned byte load from the top lane
    run_txn(mk(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FFFFFF, 1));
    run_txn(mk(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FFFFFF, 2));
    // half store to the upper half with same-cycle ack
    run_txn(mk(0, 1, 2'd1, 0, 32'h0A2, 32'h1234ABCD, 32'h0, 0));
    // misaligned word load
    run_txn(mk(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0));
    // branch resolving while a load is pending
    t = mk(1, 0, 2'd1, 0, 32'h2002, 32'h0, 32'h0000_8001, 3);
    t.br = 1; t.zero = 1;
    run_txn(t);
    idle(2);

    // reset in WAIT aborts the access
    t = mk(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 0);
    drive(t);
    repeat (3) begin @(negedge clk); check("rstwait_req", o_MEM_mem_Req, 1); end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rstwait_req_drop", o_MEM_mem_Req, 0);
    check("rstwait_stall", o_stall, 0);
    check("rstwait_wb_valid", o_WB_valid, 0);
    check("rstwait_memdata", o_WB_data_MemData, 0);
    check("rstwait_regaddr", o_WB_data_RegAddrW, 0);
    @(posedge clk); #1;
    i_MEM_valid = 0;
    rst = 0;
    idle(2);

    for (int i = 0; i < 250; i++) run_txn(rand_txn());
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
